// File: rtl/video_layer_mixer.sv
// Purpose : mixes NUM_LAYERS 1-bit video layers into {R,G,B} through a two-bank palette.
// Latency : exactly 2 ce_pix-enabled pixels from layer_on/timing inputs to rgb_out/timing outputs.
// Backpressure: none; ce_pix=0 freezes every pipeline register and output.
//
// Ports:
//   clk_vid, reset                    video clock, synchronous active-high reset
//   ce_pix                            pixel enable
//   layer_on[NUM_LAYERS]              per-layer lit bit for the current pixel
//   inv_req                           screen inversion request
//   color_mode                        palette bank used for lookup (0 mono, 1 colour)
//   hsync/vsync/hblank/vblank_in      core timing, delayed alongside the pixel
//   pal_we/pal_bank/pal_addr/pal_data palette write port (any clk_vid cycle)
//   rgb_out                           {R,G,B} mixed pixel
//   hsync/vsync/hblank/vblank_out     timing aligned with rgb_out
//   inv_active                        inversion currently applied by the mixing stage
module video_layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int CW         = 4,
    parameter int INV_MODE   = 0,
    parameter logic [NUM_LAYERS*3*CW-1:0] PAL_MONO  = '0,
    parameter logic [NUM_LAYERS*3*CW-1:0] PAL_COLOR = '0
) (
    input  logic                  clk_vid,
    input  logic                  reset,
    input  logic                  ce_pix,
    input  logic [NUM_LAYERS-1:0] layer_on,
    input  logic                  inv_req,
    input  logic                  color_mode,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblank_in,
    input  logic                  vblank_in,
    input  logic                  pal_we,
    input  logic                  pal_bank,
    input  logic [2:0]            pal_addr,
    input  logic [3*CW-1:0]       pal_data,
    output logic [3*CW-1:0]       rgb_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblank_out,
    output logic                  vblank_out,
    output logic                  inv_active
);

    localparam int PW    = 3 * CW;
    // Wide enough that summing every layer at full scale never wraps.
    localparam int ACC_W = CW + $clog2(NUM_LAYERS) + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-CW){1'b0}}, {CW{1'b1}}};

    // ------------------------------------------------------------------
    // Palette banks
    // ------------------------------------------------------------------
    logic [PW-1:0] pal_mono  [NUM_LAYERS];
    logic [PW-1:0] pal_color [NUM_LAYERS];

    // Address decode by loop: addresses at or above NUM_LAYERS match no
    // entry and are dropped rather than aliasing onto a real layer.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                pal_mono[i]  <= PAL_MONO[i*PW +: PW];
                pal_color[i] <= PAL_COLOR[i*PW +: PW];
            end
        end else if (pal_we) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (pal_addr == 3'(i)) begin
                    if (pal_bank) pal_color[i] <= pal_data;
                    else          pal_mono[i]  <= pal_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-layer palette lookup, timing capture
    // ------------------------------------------------------------------
    logic [PW-1:0] s1_ent [NUM_LAYERS];
    logic          s1_hs, s1_vs, s1_hb, s1_vb;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) s1_ent[i] <= '0;
            s1_hs <= 1'b0;
            s1_vs <= 1'b0;
            s1_hb <= 1'b0;
            s1_vb <= 1'b0;
        end else if (ce_pix) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (layer_on[i]) s1_ent[i] <= color_mode ? pal_color[i] : pal_mono[i];
                else             s1_ent[i] <= '0;
            end
            s1_hs <= hsync_in;
            s1_vs <= vsync_in;
            s1_hb <= hblank_in;
            s1_vb <= vblank_in;
        end
    end

    // ------------------------------------------------------------------
    // Inversion control
    // ------------------------------------------------------------------
    logic inv;
    logic inv_acc;
    logic vs_prev;
    logic vs_rise;

    assign vs_rise    = vsync_in & ~vs_prev;
    assign inv_active = inv;

    // Frame mode: requests collected during one frame become the inversion
    // state of the next frame. A request on the rising-edge pixel itself
    // seeds the new accumulator, so it lands one frame later.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            inv     <= 1'b0;
            inv_acc <= 1'b0;
            vs_prev <= 1'b0;
        end else if (ce_pix) begin
            vs_prev <= vsync_in;
            if (vs_rise) inv_acc <= inv_req;
            else         inv_acc <= inv_acc | inv_req;
            if (INV_MODE != 0) inv <= inv_req;
            else if (vs_rise)  inv <= inv_acc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturating sum, invert, blank
    // ------------------------------------------------------------------
    function automatic logic [CW-1:0] sat(input logic [ACC_W-1:0] s);
        return (s > SAT_MAX) ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    logic [ACC_W-1:0] sum_r, sum_g, sum_b;
    logic [PW-1:0]    mix;

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sum_r = sum_r + ACC_W'(s1_ent[i][3*CW-1 -: CW]);
            sum_g = sum_g + ACC_W'(s1_ent[i][2*CW-1 -: CW]);
            sum_b = sum_b + ACC_W'(s1_ent[i][CW-1:0]);
        end
        mix = {sat(sum_r), sat(sum_g), sat(sum_b)} ^ {PW{inv}};
        // Blanking wins over inversion so borders stay black.
        if (s1_hb | s1_vb) mix = '0;
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            rgb_out    <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
        end else if (ce_pix) begin
            rgb_out    <= mix;
            hsync_out  <= s1_hs;
            vsync_out  <= s1_vs;
            hblank_out <= s1_hb;
            vblank_out <= s1_vb;
        end
    end

endmodule
